// File: rtl/interp_ctrl.sv
// Quarter-pel interpolation block controller: row fill, filter wait,
// output drain and completion pulse, one block per accepted start.
module interp_ctrl #(
   parameter int FILL_ROWS = 15,
   parameter int OUT_WORDS = 40,
   parameter int FILT_LAT  = 4
) (
   input  logic       i_clock,
   input  logic       i_reset,
   input  logic       i_start,
   input  logic [1:0] i_frac_x,
   input  logic [1:0] i_frac_y,
   input  logic       i_in_valid,
   output logic       o_in_ready,
   output logic       o_sr_load_L,
   output logic       o_of_load_L,
   output logic [7:0] o_of_sel,
   output logic [3:0] o_phase,
   output logic       o_busy,
   output logic       o_done
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FILL,
      S_FILTER,
      S_DRAIN,
      S_DONE
   } state_t;

   localparam logic [7:0] LP_ROW_LAST = 8'(FILL_ROWS - 1);
   localparam logic [7:0] LP_SEL_LAST = 8'(OUT_WORDS - 1);
   localparam logic [7:0] LP_LAT_LAST = 8'(FILT_LAT - 1);
   localparam bit         LP_NO_WAIT  = (FILT_LAT == 0);

   state_t     r_state;
   logic [7:0] r_row;
   logic [7:0] r_wait;
   logic [7:0] r_sel;
   logic       r_ready;
   logic       r_of_load_L;
   logic [3:0] r_phase;
   logic       r_busy;
   logic       r_done;
   logic       w_xfer;

   // r_ready is only ever set in FILL, so a transfer implies FILL
   assign w_xfer = r_ready & i_in_valid;

   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         r_state     <= S_IDLE;
         r_row       <= '0;
         r_wait      <= '0;
         r_sel       <= '0;
         r_ready     <= 1'b0;
         r_of_load_L <= 1'b1;
         r_phase     <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
      end else begin
         r_done <= 1'b0;
         unique case (r_state)
            S_IDLE: begin
               if (i_start) begin
                  r_state <= S_FILL;
                  r_phase <= {i_frac_y, i_frac_x};
                  r_row   <= '0;
                  r_wait  <= '0;
                  r_sel   <= '0;
                  r_ready <= 1'b1;
                  r_busy  <= 1'b1;
               end
            end
            S_FILL: begin
               if (w_xfer) begin
                  if (r_row == LP_ROW_LAST) begin
                     r_row   <= '0;
                     r_ready <= 1'b0;
                     // integer-pel blocks need no filtering
                     if (r_phase == 4'd0 || LP_NO_WAIT) begin
                        r_state     <= S_DRAIN;
                        r_of_load_L <= 1'b0;
                        r_sel       <= '0;
                     end else begin
                        r_state <= S_FILTER;
                        r_wait  <= '0;
                     end
                  end else begin
                     r_row <= r_row + 8'd1;
                  end
               end
            end
            S_FILTER: begin
               if (r_wait == LP_LAT_LAST) begin
                  r_state     <= S_DRAIN;
                  r_wait      <= '0;
                  r_of_load_L <= 1'b0;
                  r_sel       <= '0;
               end else begin
                  r_wait <= r_wait + 8'd1;
               end
            end
            S_DRAIN: begin
               if (r_sel == LP_SEL_LAST) begin
                  r_state     <= S_DONE;
                  r_of_load_L <= 1'b1;
                  r_sel       <= '0;
                  r_done      <= 1'b1;
               end else begin
                  r_sel <= r_sel + 8'd1;
               end
            end
            S_DONE: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign o_in_ready  = r_ready;
   assign o_sr_load_L = ~w_xfer;
   assign o_of_load_L = r_of_load_L;
   assign o_of_sel    = r_sel;
   assign o_phase     = r_phase;
   assign o_busy      = r_busy;
   assign o_done      = r_done;

endmodule
